// File: rtl/char_buf_ctrl.sv
// char_buf_ctrl: write-side controller for the 80x30 text character buffer.
// Owns the edit cursor, turns keyboard ASCII into RAM writes (auto-advance,
// CR, backspace), sweeps the screen with spaces on a clear request, and
// shares the single RAM write port with an optional CPU write port.
// Optional feature macro: CHAR_BUF_CPU_PORT_EN (CPU port joins arbitration).
module char_buf_ctrl #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int DATA_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  kb_valid_i,
  input  logic [DATA_WIDTH-1:0] kb_char_i,
  output logic                  kb_ready_o,
  input  logic [3:0]            arrow_i,     // {up, down, left, right}
  input  logic                  clr_req_i,
  input  logic                  cpu_req_i,
  input  logic [11:0]           cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_data_i,
  output logic                  cpu_gnt_o,
  output logic                  ram_we_o,
  output logic [11:0]           ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  output logic [6:0]            cur_x_o,
  output logic [4:0]            cur_y_o,
  output logic                  busy_o
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  localparam logic [6:0]            X_MAX    = 7'(COLS - 1);
  localparam logic [4:0]            Y_MAX    = 5'(ROWS - 1);
  localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] CH_TILDE = DATA_WIDTH'(8'h7E);
  localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(8'h08);

  state_e                state_q, state_d;
  logic [6:0]            sx_q, sx_d;        // sweep column of the next cell to clear
  logic [4:0]            sy_q, sy_d;        // sweep row of the next cell to clear
  logic [6:0]            cur_x_q, cur_x_d;
  logic [4:0]            cur_y_q, cur_y_d;
  logic                  ram_we_q, ram_we_d;
  logic [11:0]           ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  cpu_gnt_q, cpu_gnt_d;
  logic                  busy_q, busy_d;

  logic cpu_take;
  logic sweep_last;
  logic kb_printable;
  logic [6:0] adv_x, ret_x, right_x, left_x;
  logic [4:0] adv_y, ret_y, down_y, up_y;

`ifdef CHAR_BUF_CPU_PORT_EN
  assign cpu_take = cpu_req_i;
`else
  // CPU port is inert in this build; the request is deliberately ignored.
  logic unused_cpu_req;
  assign unused_cpu_req = cpu_req_i;
  assign cpu_take       = 1'b0;
`endif

  assign sweep_last   = (sx_q == X_MAX) && (sy_q == Y_MAX);
  assign kb_printable = (kb_char_i >= CH_SPACE) && (kb_char_i <= CH_TILDE);
  assign kb_ready_o   = (state_q == ST_IDLE) && !clr_req_i && !cpu_take;

  // Single-step cursor moves, each wrapping on its own axis.
  assign right_x = (cur_x_q == X_MAX) ? 7'd0 : cur_x_q + 7'd1;
  assign left_x  = (cur_x_q == 7'd0) ? X_MAX : cur_x_q - 7'd1;
  assign down_y  = (cur_y_q == Y_MAX) ? 5'd0 : cur_y_q + 5'd1;
  assign up_y    = (cur_y_q == 5'd0) ? Y_MAX : cur_y_q - 5'd1;
  // Text-flow moves: column wrap carries into the row.
  assign adv_x   = right_x;
  assign adv_y   = (cur_x_q == X_MAX) ? down_y : cur_y_q;
  assign ret_x   = left_x;
  assign ret_y   = (cur_x_q == 7'd0) ? up_y : cur_y_q;

  // State and datapath registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sx_q       <= '0;
      sy_q       <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      cpu_gnt_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      cpu_gnt_q  <= cpu_gnt_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: a clear request starts the sweep, the last cell ends it.
  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (clr_req_i)  state_d = ST_CLEAR;
      ST_CLEAR: if (sweep_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: fixed-priority pick of at most one write per cycle.
  always_comb begin
    sx_d       = sx_q;
    sy_d       = sy_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    cpu_gnt_d  = 1'b0;
    busy_d     = 1'b0;
    if (state_q == ST_CLEAR) begin
      ram_we_d   = 1'b1;
      busy_d     = 1'b1;
      ram_addr_d = {sy_q, sx_q};
      ram_din_d  = CH_SPACE;
      if (sx_q == X_MAX) begin
        sx_d = 7'd0;
        sy_d = (sy_q == Y_MAX) ? 5'd0 : sy_q + 5'd1;
      end else begin
        sx_d = sx_q + 7'd1;
      end
      if (sweep_last) begin
        cur_x_d = 7'd0;
        cur_y_d = 5'd0;
      end
    end else if (clr_req_i) begin
      // Cell {0,0} is written on the request edge itself, so the sweep
      // counter continues from the cell after it.
      ram_we_d   = 1'b1;
      busy_d     = 1'b1;
      ram_addr_d = '0;
      ram_din_d  = CH_SPACE;
      sx_d       = (X_MAX == 7'd0) ? 7'd0 : 7'd1;
      sy_d       = (X_MAX == 7'd0) ? 5'd1 : 5'd0;
    end else if (cpu_take) begin
      ram_we_d   = 1'b1;
      ram_addr_d = cpu_addr_i;
      ram_din_d  = cpu_data_i;
      cpu_gnt_d  = 1'b1;
    end else if (kb_valid_i) begin
      if (kb_printable) begin
        ram_we_d   = 1'b1;
        ram_addr_d = {cur_y_q, cur_x_q};
        ram_din_d  = kb_char_i;
        cur_x_d    = adv_x;
        cur_y_d    = adv_y;
      end else if (kb_char_i == CH_CR) begin
        cur_x_d = 7'd0;
        cur_y_d = down_y;
      end else if (kb_char_i == CH_BS) begin
        ram_we_d   = 1'b1;
        ram_addr_d = {ret_y, ret_x};
        ram_din_d  = CH_SPACE;
        cur_x_d    = ret_x;
        cur_y_d    = ret_y;
      end
    end else if (arrow_i[0]) begin
      cur_x_d = right_x;
    end else if (arrow_i[1]) begin
      cur_x_d = left_x;
    end else if (arrow_i[2]) begin
      cur_y_d = down_y;
    end else if (arrow_i[3]) begin
      cur_y_d = up_y;
    end
  end

  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign cpu_gnt_o  = cpu_gnt_q;
  assign busy_o     = busy_q;
  assign cur_x_o    = cur_x_q;
  assign cur_y_o    = cur_y_q;

endmodule

// File: tb/tb_char_buf_ctrl.sv
// tb_char_buf_ctrl: directed-vector bench for char_buf_ctrl with
// hand-computed expected values. Follows CHAR_BUF_CPU_PORT_EN like the DUT.
`timescale 1ns/1ps
module tb_char_buf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kb_valid;
  logic [6:0]  kb_char;
  logic        kb_ready;
  logic [3:0]  arrow;
  logic        clr_req;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic [6:0]  cpu_data;
  logic        cpu_gnt;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [6:0]  ram_din;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  char_buf_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kb_valid_i (kb_valid),
    .kb_char_i  (kb_char),
    .kb_ready_o (kb_ready),
    .arrow_i    (arrow),
    .clr_req_i  (clr_req),
    .cpu_req_i  (cpu_req),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_data),
    .cpu_gnt_o  (cpu_gnt),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .cur_x_o    (cur_x),
    .cur_y_o    (cur_y),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [11:0] addr, input logic [6:0] din);
    check({tag, ".we"}, 32'(ram_we), 32'd1);
    check({tag, ".addr"}, 32'(ram_addr), 32'(addr));
    check({tag, ".din"}, 32'(ram_din), 32'(din));
  endtask

  task automatic check_cur(input string tag, input logic [6:0] x, input logic [4:0] y);
    check({tag, ".x"}, 32'(cur_x), 32'(x));
    check({tag, ".y"}, 32'(cur_y), 32'(y));
  endtask

  task automatic key(input logic [6:0] c);
    kb_valid = 1'b1;
    kb_char  = c;
    tick();
    kb_valid = 1'b0;
  endtask

  task automatic pulse_arrow(input logic [3:0] a);
    arrow = a;
    tick();
    arrow = 4'b0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int addr_errs;
    int rdy_errs;
    logic [6:0] last_x;
    logic [4:0] last_y;
    logic last_rdy;

    rst_n = 1'b0; kb_valid = 1'b0; kb_char = '0; arrow = '0;
    clr_req = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    @(negedge clk);
    tick(); tick();
    check("rst.we", 32'(ram_we), 32'd0);
    check("rst.addr", 32'(ram_addr), 32'd0);
    check("rst.din", 32'(ram_din), 32'd0);
    check("rst.gnt", 32'(cpu_gnt), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check_cur("rst.cur", 7'd0, 5'd0);
    rst_n = 1'b1;
    tick();
    check("idle.ready", 32'(kb_ready), 32'd1);

    // Printable byte at (0,0).
    key(7'h41);
    check_write("kbA", {5'd0, 7'd0}, 7'h41);
    check_cur("kbA.cur", 7'd1, 5'd0);
    tick();
    check("kbA.we_drop", 32'(ram_we), 32'd0);

    // Arrows: (1,0) -left-> (0,0) -left-> (79,0) -up-> (79,29).
    pulse_arrow(4'b0010);
    pulse_arrow(4'b0010);
    check_cur("arrow.left_wrap", 7'd79, 5'd0);
    pulse_arrow(4'b1000);
    check_cur("arrow.up_wrap", 7'd79, 5'd29);
    check("arrow.no_write", 32'(ram_we), 32'd0);

    // Advance wraps to (0,0); backspace retreats back to the corner.
    key(7'h42);
    check_write("kbB", {5'd29, 7'd79}, 7'h42);
    check_cur("kbB.cur", 7'd0, 5'd0);
    key(7'h08);
    check_write("bs", {5'd29, 7'd79}, 7'h20);
    check_cur("bs.cur", 7'd79, 5'd29);

    // Right wraps column only; down wraps row.
    pulse_arrow(4'b0001);
    check_cur("arrow.right_wrap", 7'd0, 5'd29);
    pulse_arrow(4'b0100);
    check_cur("arrow.down_wrap", 7'd0, 5'd0);
    pulse_arrow(4'b1111);
    check_cur("arrow.prio_right", 7'd1, 5'd0);
    pulse_arrow(4'b0110);
    check_cur("arrow.prio_left", 7'd0, 5'd0);

    for (int i = 0; i < 37; i++) pulse_arrow(4'b0001);
    for (int i = 0; i < 4; i++) pulse_arrow(4'b0100);
    check_cur("arrow.walk", 7'd37, 5'd4);
    key(7'h0D);
    check("cr.we", 32'(ram_we), 32'd0);
    check_cur("cr.cur", 7'd0, 5'd5);
    kb_valid = 1'b1; kb_char = 7'h07;
    #1;
    check("bel.ready", 32'(kb_ready), 32'd1);
    tick();
    kb_valid = 1'b0;
    check("bel.we", 32'(ram_we), 32'd0);
    check_cur("bel.cur", 7'd0, 5'd5);

    // Full clear with a keyboard byte held pending throughout.
    clr_req = 1'b1; kb_valid = 1'b1; kb_char = 7'h44;
    #1;
    check("clr.ready_low", 32'(kb_ready), 32'd0);
    tick();
    clr_req = 1'b0;
    n = 0; addr_errs = 0; rdy_errs = 0;
    last_x = '1; last_y = '1; last_rdy = 1'b0;
    while (busy === 1'b1 && n < 2500) begin
      if (ram_we !== 1'b1 || ram_din !== 7'h20 ||
          ram_addr !== {5'(n / 80), 7'(n % 80)}) addr_errs++;
      if (n < 2399 && kb_ready !== 1'b0) rdy_errs++;
      if (n == 2399) begin
        last_x = cur_x; last_y = cur_y; last_rdy = kb_ready;
      end
      n++;
      tick();
    end
    check("clr.busy_cycles", 32'(n), 32'd2400);
    check("clr.sweep_errs", 32'(addr_errs), 32'd0);
    check("clr.ready_errs", 32'(rdy_errs), 32'd0);
    check("clr.end_x", 32'(last_x), 32'd0);
    check("clr.end_y", 32'(last_y), 32'd0);
    check("clr.end_ready", 32'(last_rdy), 32'd1);
    check_write("clr.held_kb", {5'd0, 7'd0}, 7'h44);
    check_cur("clr.held_kb.cur", 7'd1, 5'd0);
    kb_valid = 1'b0;
    tick();

    // Simultaneous CPU, keyboard and arrow requests.
    cpu_req = 1'b1; cpu_addr = 12'h105; cpu_data = 7'h5A;
    kb_valid = 1'b1; kb_char = 7'h43; arrow = 4'b0001;
`ifdef CHAR_BUF_CPU_PORT_EN
    #1;
    check("cpu.ready_low", 32'(kb_ready), 32'd0);
    tick();
    cpu_req = 1'b0; arrow = 4'b0000;
    check("cpu.gnt", 32'(cpu_gnt), 32'd1);
    check_write("cpu", 12'h105, 7'h5A);
    check_cur("cpu.cur", 7'd1, 5'd0);
    tick();
    kb_valid = 1'b0;
    check("cpu.gnt_pulse", 32'(cpu_gnt), 32'd0);
    check_write("cpu.kb", {5'd0, 7'd1}, 7'h43);
    check_cur("cpu.kb.cur", 7'd2, 5'd0);
`else
    #1;
    check("nocpu.ready", 32'(kb_ready), 32'd1);
    tick();
    cpu_req = 1'b0; arrow = 4'b0000; kb_valid = 1'b0;
    check("nocpu.gnt", 32'(cpu_gnt), 32'd0);
    check_write("nocpu.kb", {5'd0, 7'd1}, 7'h43);
    check_cur("nocpu.kb.cur", 7'd2, 5'd0);
`endif
    tick();
    check("prio.idle_we", 32'(ram_we), 32'd0);
    check("prio.idle_gnt", 32'(cpu_gnt), 32'd0);
    check_cur("prio.arrow_dropped", 7'd2, 5'd0);

    // Reset in the middle of a sweep.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (999) tick();
    check("midrst.busy_before", 32'(busy), 32'd1);
    check("midrst.addr_before", 32'(ram_addr), 32'(12'({5'd12, 7'd39})));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.we", 32'(ram_we), 32'd0);
    check("midrst.addr", 32'(ram_addr), 32'd0);
    check_cur("midrst.cur", 7'd0, 5'd0);
    tick(); tick();
    check("midrst.stays_idle", 32'(busy), 32'd0);
    check("midrst.ready", 32'(kb_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
